// File: rtl/lsu_mem_master_if.sv
// Load/store pipeline handshake plus the simple RAM port, bundled for lsu_mem_master.
// master: the LSU side. slave: the pipeline/RAM environment side.
interface lsu_mem_master_if;
   logic        req_valid_i;
   logic        req_wen_i;
   logic [63:0] req_addr_i;
   logic [63:0] req_wdata_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic        req_ready_o;

   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [63:0] resp_rdata_o;
   logic        resp_err_o;

   logic [31:0] ram_raddr_o;
   logic        ram_ren_o;
   logic [63:0] ram_rdata_i;
   logic        ram_rready_i;

   logic [31:0] ram_waddr_o;
   logic [63:0] ram_wdata_o;
   logic [63:0] ram_wmask_o;
   logic        ram_wen_o;
   logic        ram_wready_i;
   logic        ram_bvalid_i;

   modport master (
      input  req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
      output req_ready_o,
      output resp_valid_o, resp_rdata_o, resp_err_o,
      input  resp_ready_i,
      output ram_raddr_o, ram_ren_o,
      input  ram_rdata_i, ram_rready_i,
      output ram_waddr_o, ram_wdata_o, ram_wmask_o, ram_wen_o,
      input  ram_wready_i, ram_bvalid_i
   );

   modport slave (
      output req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
      input  req_ready_o,
      input  resp_valid_o, resp_rdata_o, resp_err_o,
      output resp_ready_i,
      input  ram_raddr_o, ram_ren_o,
      output ram_rdata_i, ram_rready_i,
      input  ram_waddr_o, ram_wdata_o, ram_wmask_o, ram_wen_o,
      output ram_wready_i, ram_bvalid_i
   );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding LSU-to-RAM master: load response at accept+2, store at accept+3, fault at accept+1.
// Takes one request only in IDLE; holds the response until resp_ready_i; RAM waits bounded by TIMEOUT.
module lsu_mem_master #(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   lsu_mem_master_if.master  bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      WR      = 3'd2,
      WR_RESP = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q;
   logic [63:0]      wdata_q;
   logic [63:0]      wmask_q;
   logic [1:0]       size_q;
   logic             uns_q;
   logic [63:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             accept;
   logic             fault;
   logic             timeout;
   logic             req_ready;
   logic             resp_valid;
   logic             ren;
   logic             wen;
   logic [63:0]      mask_in;
   logic [63:0]      load_ext;

   // Only the low 2 GiB window above 0x8000_0000 is backed by RAM.
   assign fault   = (bus.req_addr_i[63:32] != 32'd0) || !bus.req_addr_i[31];
   assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      mask_in = 64'd0;
      case (bus.req_size_i)
         2'd0:    mask_in = 64'h0000_0000_0000_00FF;
         2'd1:    mask_in = 64'h0000_0000_0000_FFFF;
         2'd2:    mask_in = 64'h0000_0000_FFFF_FFFF;
         default: mask_in = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   end

   // RAM returns data already aligned to the byte address, so only extension is needed.
   always_comb begin
      load_ext = 64'd0;
      case (size_q)
         2'd0: load_ext = uns_q ? {56'd0, bus.ram_rdata_i[7:0]}
                                : {{56{bus.ram_rdata_i[7]}}, bus.ram_rdata_i[7:0]};
         2'd1: load_ext = uns_q ? {48'd0, bus.ram_rdata_i[15:0]}
                                : {{48{bus.ram_rdata_i[15]}}, bus.ram_rdata_i[15:0]};
         2'd2: load_ext = uns_q ? {32'd0, bus.ram_rdata_i[31:0]}
                                : {{32{bus.ram_rdata_i[31]}}, bus.ram_rdata_i[31:0]};
         default: load_ext = bus.ram_rdata_i;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      rdata_d    = rdata_q;
      err_d      = err_q;
      accept     = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      ren        = 1'b0;
      wen        = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid_i) begin
               accept = 1'b1;
               if (fault) begin
                  state_d = RESP;
                  rdata_d = 64'd0;
                  err_d   = 1'b1;
               end else if (bus.req_wen_i) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            ren = 1'b1;
            if (bus.ram_rready_i) begin
               state_d = RESP;
               rdata_d = load_ext;
               err_d   = 1'b0;
            end else if (timeout) begin
               state_d = RESP;
               rdata_d = 64'd0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WR: begin
            if (bus.ram_wready_i) begin
               wen     = 1'b1;
               state_d = WR_RESP;
            end else if (timeout) begin
               state_d = RESP;
               rdata_d = 64'd0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WR_RESP: begin
            if (bus.ram_bvalid_i) begin
               state_d = RESP;
               rdata_d = 64'd0;
               err_d   = 1'b0;
            end else if (timeout) begin
               state_d = RESP;
               rdata_d = 64'd0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (bus.resp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Store data is masked at capture so the RAM port never sees bytes outside the access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= 32'd0;
         wdata_q <= 64'd0;
         wmask_q <= 64'd0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
      end else if (accept) begin
         addr_q  <= bus.req_addr_i[31:0];
         wdata_q <= bus.req_wdata_i & mask_in;
         wmask_q <= mask_in;
         size_q  <= bus.req_size_i;
         uns_q   <= bus.req_unsigned_i;
      end
   end

   assign bus.req_ready_o  = req_ready;
   assign bus.resp_valid_o = resp_valid;
   assign bus.resp_rdata_o = rdata_q;
   assign bus.resp_err_o   = err_q;
   assign bus.ram_ren_o    = ren;
   assign bus.ram_raddr_o  = addr_q;
   assign bus.ram_wen_o    = wen;
   assign bus.ram_waddr_o  = addr_q;
   assign bus.ram_wdata_o  = wdata_q;
   assign bus.ram_wmask_o  = wmask_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: loads, stores, faults, timeouts, response stall and reset abort.
module tb_lsu_mem_master;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] mem_q;

   lsu_mem_master_if bus ();

   lsu_mem_master #(.TIMEOUT(TIMEOUT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [1:0] size, input logic uns);
      bus.req_valid_i    = 1'b1;
      bus.req_wen_i      = wen;
      bus.req_addr_i     = addr;
      bus.req_wdata_i    = wdata;
      bus.req_size_i     = size;
      bus.req_unsigned_i = uns;
   endtask

   task automatic finish_resp(input string tag);
      bus.resp_ready_i = 1'b1;
      step();
      bus.resp_ready_i = 1'b0;
      chk({tag, "_done_vld"}, 64'(bus.resp_valid_o), 64'd0);
      chk({tag, "_done_rdy"}, 64'(bus.req_ready_o), 64'd1);
   endtask

   task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                          input logic uns, input logic [63:0] data, input int delay,
                          input int hold, input logic [63:0] exp);
      drive_req(1'b0, addr, 64'd0, size, uns);
      bus.ram_rdata_i  = data;
      bus.ram_rready_i = 1'b0;
      #1;
      chk({tag, "_idle_rdy"}, 64'(bus.req_ready_o), 64'd1);
      step();
      bus.req_valid_i = 1'b0;
      chk({tag, "_ren"}, 64'(bus.ram_ren_o), 64'd1);
      chk({tag, "_raddr"}, 64'(bus.ram_raddr_o), {32'd0, addr[31:0]});
      chk({tag, "_rd_rdy"}, 64'(bus.req_ready_o), 64'd0);
      for (int i = 0; i < delay; i++) begin
         step();
         chk({tag, "_wait_ren"}, 64'(bus.ram_ren_o), 64'd1);
         chk({tag, "_wait_vld"}, 64'(bus.resp_valid_o), 64'd0);
      end
      bus.ram_rready_i = 1'b1;
      step();
      bus.ram_rready_i = 1'b0;
      chk({tag, "_vld"}, 64'(bus.resp_valid_o), 64'd1);
      chk({tag, "_rdata"}, bus.resp_rdata_o, exp);
      chk({tag, "_err"}, 64'(bus.resp_err_o), 64'd0);
      chk({tag, "_ren_off"}, 64'(bus.ram_ren_o), 64'd0);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_hold_vld"}, 64'(bus.resp_valid_o), 64'd1);
         chk({tag, "_hold_rdata"}, bus.resp_rdata_o, exp);
         chk({tag, "_hold_rdy"}, 64'(bus.req_ready_o), 64'd0);
      end
      finish_resp(tag);
   endtask

   task automatic do_store(input string tag, input logic [63:0] addr, input logic [1:0] size,
                           input logic [63:0] wdata, input int delay,
                           input logic [63:0] exp_mask, input logic [63:0] exp_wdata);
      drive_req(1'b1, addr, wdata, size, 1'b0);
      bus.ram_wready_i = 1'b0;
      bus.ram_bvalid_i = 1'b0;
      step();
      bus.req_valid_i = 1'b0;
      // bvalid while still in WR must not complete the store
      for (int i = 0; i < delay; i++) begin
         bus.ram_bvalid_i = 1'b1;
         #1;
         chk({tag, "_wait_wen"}, 64'(bus.ram_wen_o), 64'd0);
         step();
         chk({tag, "_wait_vld"}, 64'(bus.resp_valid_o), 64'd0);
      end
      bus.ram_bvalid_i = 1'b0;
      bus.ram_wready_i = 1'b1;
      #1;
      chk({tag, "_wen"}, 64'(bus.ram_wen_o), 64'd1);
      chk({tag, "_ren"}, 64'(bus.ram_ren_o), 64'd0);
      chk({tag, "_waddr"}, 64'(bus.ram_waddr_o), {32'd0, addr[31:0]});
      chk({tag, "_wmask"}, bus.ram_wmask_o, exp_mask);
      chk({tag, "_wdata"}, bus.ram_wdata_o, exp_wdata);
      mem_q = (mem_q & ~bus.ram_wmask_o) | bus.ram_wdata_o;
      step();
      bus.ram_wready_i = 1'b0;
      chk({tag, "_wen_once"}, 64'(bus.ram_wen_o), 64'd0);
      chk({tag, "_wresp_vld"}, 64'(bus.resp_valid_o), 64'd0);
      bus.ram_bvalid_i = 1'b1;
      step();
      bus.ram_bvalid_i = 1'b0;
      chk({tag, "_vld"}, 64'(bus.resp_valid_o), 64'd1);
      chk({tag, "_err"}, 64'(bus.resp_err_o), 64'd0);
      chk({tag, "_rdata"}, bus.resp_rdata_o, 64'd0);
      finish_resp(tag);
   endtask

   initial begin
      rst                = 1'b0;
      bus.req_valid_i    = 1'b0;
      bus.req_wen_i      = 1'b0;
      bus.req_addr_i     = 64'd0;
      bus.req_wdata_i    = 64'd0;
      bus.req_size_i     = 2'd0;
      bus.req_unsigned_i = 1'b0;
      bus.resp_ready_i   = 1'b0;
      bus.ram_rdata_i    = 64'd0;
      bus.ram_rready_i   = 1'b0;
      bus.ram_wready_i   = 1'b0;
      bus.ram_bvalid_i   = 1'b0;
      mem_q              = 64'hFFFF_FFFF_FFFF_0000;
      #1;
      chk("rst_req_rdy", 64'(bus.req_ready_o), 64'd1);
      chk("rst_resp_vld", 64'(bus.resp_valid_o), 64'd0);
      chk("rst_resp_err", 64'(bus.resp_err_o), 64'd0);
      chk("rst_rdata", bus.resp_rdata_o, 64'd0);
      chk("rst_ren", 64'(bus.ram_ren_o), 64'd0);
      chk("rst_wen", 64'(bus.ram_wen_o), 64'd0);
      chk("rst_raddr", 64'(bus.ram_raddr_o), 64'd0);
      chk("rst_waddr", 64'(bus.ram_waddr_o), 64'd0);
      chk("rst_wdata", bus.ram_wdata_o, 64'd0);
      chk("rst_wmask", bus.ram_wmask_o, 64'd0);
      step();
      step();
      rst = 1'b1;
      step();

      // Load extraction vectors
      do_load("ld_b_s", 64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_0000_0080, 0, 0,
              64'hFFFF_FFFF_FFFF_FF80);
      do_load("ld_b_u", 64'h8000_0000, 2'd0, 1'b1, 64'hAAAA_AAAA_AAAA_AA80, 2, 0,
              64'h0000_0000_0000_0080);
      do_load("ld_h_s", 64'h8000_0010, 2'd1, 1'b0, 64'h0000_0000_0000_8001, 0, 0,
              64'hFFFF_FFFF_FFFF_8001);
      do_load("ld_w_pos", 64'h8000_0020, 2'd2, 1'b0, 64'h1111_1111_7654_3210, 1, 0,
              64'h0000_0000_7654_3210);
      do_load("ld_w_s", 64'h8000_0024, 2'd2, 1'b0, 64'h0000_0000_8765_4321, 0, 0,
              64'hFFFF_FFFF_8765_4321);
      do_load("ld_w_u", 64'h8000_0028, 2'd2, 1'b1, 64'hFFFF_FFFF_8765_4321, 0, 0,
              64'h0000_0000_8765_4321);
      do_load("ld_d", 64'hFFFF_FFF8, 2'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 0, 0,
              64'hDEAD_BEEF_0123_4567);
      do_load("ld_stall", 64'h8000_0030, 2'd1, 1'b1, 64'h0000_0000_0000_BEEF, 0, 5,
              64'h0000_0000_0000_BEEF);

      // Stores, then read back through the RAM model
      do_store("st_h", 64'h8000_0102, 2'd1, 64'h1234_5678_9ABC_DEF0, 0,
               64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_DEF0);
      do_load("rb_h_u", 64'h8000_0102, 2'd1, 1'b1, mem_q, 0, 0, 64'h0000_0000_0000_DEF0);
      do_load("rb_h_s", 64'h8000_0102, 2'd1, 1'b0, mem_q, 0, 0, 64'hFFFF_FFFF_FFFF_DEF0);
      do_store("st_b", 64'h8000_0200, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 2,
               64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00AB);
      do_store("st_w", 64'h8000_0204, 2'd2, 64'hCAFE_F00D_1357_9BDF, 0,
               64'h0000_0000_FFFF_FFFF, 64'h0000_0000_1357_9BDF);
      do_store("st_d", 64'h8000_0208, 2'd3, 64'hCAFE_F00D_1357_9BDF, 1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hCAFE_F00D_1357_9BDF);

      // Access faults: below the RAM window and above 4 GiB
      drive_req(1'b0, 64'h0000_0000_0000_1000, 64'd0, 2'd2, 1'b0);
      bus.ram_rready_i = 1'b1;
      #1;
      chk("flt_ld_ren_acc", 64'(bus.ram_ren_o), 64'd0);
      step();
      bus.req_valid_i = 1'b0;
      chk("flt_ld_vld", 64'(bus.resp_valid_o), 64'd1);
      chk("flt_ld_err", 64'(bus.resp_err_o), 64'd1);
      chk("flt_ld_rdata", bus.resp_rdata_o, 64'd0);
      chk("flt_ld_ren", 64'(bus.ram_ren_o), 64'd0);
      bus.ram_rready_i = 1'b0;
      finish_resp("flt_ld");

      drive_req(1'b1, 64'h0000_0001_8000_0000, 64'h55, 2'd0, 1'b0);
      bus.ram_wready_i = 1'b1;
      step();
      bus.req_valid_i = 1'b0;
      chk("flt_st_vld", 64'(bus.resp_valid_o), 64'd1);
      chk("flt_st_err", 64'(bus.resp_err_o), 64'd1);
      chk("flt_st_wen", 64'(bus.ram_wen_o), 64'd0);
      bus.ram_wready_i = 1'b0;
      finish_resp("flt_st");

      drive_req(1'b0, 64'h0000_0000_7FFF_FFFF, 64'd0, 2'd0, 1'b0);
      step();
      bus.req_valid_i = 1'b0;
      chk("flt_edge_err", 64'(bus.resp_err_o), 64'd1);
      finish_resp("flt_edge");

      // RESP-exit cycle does not accept a waiting request
      drive_req(1'b0, 64'h0000_0000_0000_0100, 64'd0, 2'd0, 1'b0);
      step();
      drive_req(1'b0, 64'h0000_0000_8000_0008, 64'd0, 2'd0, 1'b1);
      bus.resp_ready_i = 1'b1;
      bus.ram_rdata_i  = 64'h0000_0000_0000_005A;
      bus.ram_rready_i = 1'b1;
      #1;
      chk("b2b_exit_rdy", 64'(bus.req_ready_o), 64'd0);
      step();
      bus.resp_ready_i = 1'b0;
      chk("b2b_idle_rdy", 64'(bus.req_ready_o), 64'd1);
      chk("b2b_idle_vld", 64'(bus.resp_valid_o), 64'd0);
      step();
      bus.req_valid_i = 1'b0;
      chk("b2b_ren", 64'(bus.ram_ren_o), 64'd1);
      step();
      bus.ram_rready_i = 1'b0;
      chk("b2b_vld", 64'(bus.resp_valid_o), 64'd1);
      chk("b2b_rdata", bus.resp_rdata_o, 64'h0000_0000_0000_005A);
      finish_resp("b2b");

      // Store whose write response never arrives
      drive_req(1'b1, 64'h8000_0300, 64'h77, 2'd2, 1'b0);
      bus.ram_wready_i = 1'b1;
      step();
      bus.req_valid_i = 1'b0;
      chk("to_st_wen", 64'(bus.ram_wen_o), 64'd1);
      step();
      bus.ram_wready_i = 1'b0;
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         step();
         chk("to_st_wait_vld", 64'(bus.resp_valid_o), 64'd0);
      end
      step();
      chk("to_st_vld", 64'(bus.resp_valid_o), 64'd1);
      chk("to_st_err", 64'(bus.resp_err_o), 64'd1);
      chk("to_st_rdata", bus.resp_rdata_o, 64'd0);
      chk("to_st_wen_off", 64'(bus.ram_wen_o), 64'd0);
      finish_resp("to_st");

      // Load whose read data never arrives
      drive_req(1'b0, 64'h8000_0400, 64'd0, 2'd3, 1'b0);
      bus.ram_rdata_i = 64'h1234;
      step();
      bus.req_valid_i = 1'b0;
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         step();
         chk("to_ld_wait_ren", 64'(bus.ram_ren_o), 64'd1);
      end
      step();
      chk("to_ld_vld", 64'(bus.resp_valid_o), 64'd1);
      chk("to_ld_err", 64'(bus.resp_err_o), 64'd1);
      chk("to_ld_rdata", bus.resp_rdata_o, 64'd0);
      chk("to_ld_ren_off", 64'(bus.ram_ren_o), 64'd0);
      finish_resp("to_ld");

      // Reset during RD abandons the load
      drive_req(1'b0, 64'h8000_0040, 64'd0, 2'd2, 1'b0);
      step();
      bus.req_valid_i = 1'b0;
      chk("rst_rd_ren_before", 64'(bus.ram_ren_o), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_rd_ren", 64'(bus.ram_ren_o), 64'd0);
      chk("rst_rd_rdy", 64'(bus.req_ready_o), 64'd1);
      chk("rst_rd_raddr", 64'(bus.ram_raddr_o), 64'd0);
      bus.ram_rready_i = 1'b1;
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_rd_no_vld", 64'(bus.resp_valid_o), 64'd0);
         chk("rst_rd_no_ren", 64'(bus.ram_ren_o), 64'd0);
      end
      bus.ram_rready_i = 1'b0;

      // Reset during WR_RESP; a late write completion must be ignored
      drive_req(1'b1, 64'h8000_0500, 64'h99, 2'd0, 1'b0);
      bus.ram_wready_i = 1'b1;
      step();
      bus.req_valid_i = 1'b0;
      step();
      bus.ram_wready_i = 1'b0;
      rst = 1'b0;
      #2;
      rst = 1'b1;
      bus.ram_bvalid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_wr_no_vld", 64'(bus.resp_valid_o), 64'd0);
         chk("rst_wr_rdy", 64'(bus.req_ready_o), 64'd1);
      end
      bus.ram_bvalid_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
